// File: rtl/ms_wait_timer.sv
// Blocking millisecond wait: counts +1 steps of the free-running ms_time count
// and pulses done once the loaded number of ticks has elapsed.
module ms_wait_timer #(
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TIME_W-1:0] ms_time,
  input  logic              start,
  input  logic [TIME_W-1:0] duration,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [TIME_W-1:0] remaining
);

  localparam logic [TIME_W-1:0] ZERO = TIME_W'(0);
  localparam logic [TIME_W-1:0] ONE  = TIME_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [TIME_W-1:0] r_last_ms;
  logic [TIME_W-1:0] r_remaining;
  logic [TIME_W-1:0] w_remaining_nx;
  logic [TIME_W-1:0] w_last_inc;
  logic              w_tick;
  logic              r_busy;
  logic              r_done;

  // Only an exact +1 step (wrap included) counts; a TIMERST jump to 0 does not.
  assign w_last_inc = r_last_ms + ONE;
  assign w_tick     = (ms_time == w_last_inc);

  // State register, ms history and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_ms   <= ZERO;
      r_remaining <= ZERO;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_last_ms   <= ms_time;
      r_remaining <= w_remaining_nx;
      r_busy      <= (w_state_nx == WAIT);
      r_done      <= (w_state_nx == DONE);
    end
  end

  // Next-state and next-remaining decode
  always_comb begin
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    case (r_state)
      IDLE: begin
        w_remaining_nx = ZERO;
        if (start && !cancel) begin
          if (duration != ZERO) begin
            w_state_nx     = WAIT;
            w_remaining_nx = duration;
          end else begin
            w_state_nx = DONE;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      WAIT: begin
        // Cancel takes priority over a tick arriving in the same cycle.
        if (cancel) begin
          w_state_nx     = IDLE;
          w_remaining_nx = ZERO;
        end else if (w_tick) begin
          if (r_remaining <= ONE) begin
            w_state_nx     = DONE;
            w_remaining_nx = ZERO;
          end else begin
            w_remaining_nx = r_remaining - ONE;
          end
        end else begin
          w_state_nx = WAIT;
        end
      end
      DONE: begin
        w_state_nx     = IDLE;
        w_remaining_nx = ZERO;
      end
      default: begin
        w_state_nx     = IDLE;
        w_remaining_nx = ZERO;
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_ms_wait_timer.sv
// Scoreboard bench for ms_wait_timer: stimulus queues the expected sequence of
// output states; a monitor compares every observed output change against it.
module tb_ms_wait_timer;

  logic        clk;
  logic        reset_n;
  logic [15:0] ms_time;
  logic        start;
  logic [15:0] duration;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [15:0] remaining;

  typedef struct packed {
    logic        b;
    logic        d;
    logic [15:0] r;
  } obs_t;

  obs_t exp_q[$];
  obs_t prev_obs;
  logic mon_en;
  int   n_cmp;
  int   n_bad;

  ms_wait_timer #(.TIME_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ms_time   (ms_time),
    .start     (start),
    .duration  (duration),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic d, input logic [15:0] r);
    obs_t e;
    e.b = b;
    e.d = d;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every change of {busy,done,remaining} must match the next queued entry
  always @(negedge clk) begin
    obs_t cur;
    obs_t e;
    if (mon_en) begin
      cur.b = busy;
      cur.d = done;
      cur.r = remaining;
      if (cur !== prev_obs) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got busy=%0b done=%0b rem=%0h, expected no change",
                   cur.b, cur.d, cur.r);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++;
            $display("FAIL output_seq: got busy=%0b done=%0b rem=%0h expected busy=%0b done=%0b rem=%0h",
                     cur.b, cur.d, cur.r, e.b, e.d, e.r);
          end
        end
        prev_obs = cur;
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    mon_en   = 1'b0;
    prev_obs = '0;
    reset_n  = 1'b0;
    ms_time  = 16'd10;
    start    = 1'b0;
    duration = 16'd0;
    cancel   = 1'b0;
    step(2);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_remaining", remaining, 16'd0);
    reset_n = 1'b1;
    step(2);
    mon_en = 1'b1;

    // duration 3, ticks 10->11->12->13
    push(1'b1, 1'b0, 16'd3);
    start = 1'b1; duration = 16'd3;
    step(1);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(100);
      if (k < 3) begin
        push(1'b1, 1'b0, 16'(3 - k));
      end else begin
        push(1'b0, 1'b1, 16'd0);
        push(1'b0, 1'b0, 16'd0);
      end
      ms_time = 16'(10 + k);
    end
    step(5);

    // wrap 0xFFFE -> 0xFFFF -> 0x0000 counts as two ticks
    ms_time = 16'hFFFE;
    step(3);
    push(1'b1, 1'b0, 16'd2);
    start = 1'b1; duration = 16'd2;
    step(1);
    start = 1'b0;
    step(10);
    push(1'b1, 1'b0, 16'd1);
    ms_time = 16'hFFFF;
    step(10);
    push(1'b0, 1'b1, 16'd0);
    push(1'b0, 1'b0, 16'd0);
    ms_time = 16'h0000;
    step(5);

    // TIMERST jump mid-wait is not a tick and does not abort
    ms_time = 16'h0121;
    step(3);
    push(1'b1, 1'b0, 16'd5);
    start = 1'b1; duration = 16'd5;
    step(1);
    start = 1'b0;
    step(10);
    push(1'b1, 1'b0, 16'd4);
    ms_time = 16'h0122;
    step(10);
    push(1'b1, 1'b0, 16'd3);
    ms_time = 16'h0123;
    step(10);
    ms_time = 16'h0000;
    step(10);
    chk("timerst_hold", remaining, 16'd3);
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) begin
        push(1'b1, 1'b0, 16'(3 - k));
      end else begin
        push(1'b0, 1'b1, 16'd0);
        push(1'b0, 1'b0, 16'd0);
      end
      ms_time = 16'(k);
      step(10);
    end
    step(5);

    // duration 0 -> immediate done, busy never asserted
    push(1'b0, 1'b1, 16'd0);
    push(1'b0, 1'b0, 16'd0);
    start = 1'b1; duration = 16'd0;
    step(1);
    start = 1'b0;
    step(5);
    // start with cancel in IDLE: nothing happens
    start = 1'b1; cancel = 1'b1; duration = 16'd4;
    step(1);
    start = 1'b0; cancel = 1'b0;
    step(5);

    // start during WAIT is ignored; cancel beats the final tick
    ms_time = 16'h0050;
    step(3);
    push(1'b1, 1'b0, 16'd2);
    start = 1'b1; duration = 16'd2;
    step(1);
    start = 1'b0;
    step(5);
    push(1'b1, 1'b0, 16'd1);
    ms_time = 16'h0051;
    step(5);
    start = 1'b1; duration = 16'd9;
    step(1);
    start = 1'b0;
    step(3);
    chk("start_in_wait", remaining, 16'd1);
    push(1'b0, 1'b0, 16'd0);
    ms_time = 16'h0052; cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(5);

    // async reset mid-wait clears outputs immediately
    push(1'b1, 1'b0, 16'd7);
    start = 1'b1; duration = 16'd7;
    step(1);
    start = 1'b0;
    step(3);
    push(1'b0, 1'b0, 16'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_done", {15'd0, done}, 16'd0);
    chk("async_rst_remaining", remaining, 16'd0);
    step(2);
    reset_n = 1'b1;
    step(5);

    mon_en = 1'b0;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
